// File: rtl/mult_seq_controller_if.sv
// Handshake and datapath-control bundle for the sequential multiplier controller.
// The master side is the controller: it issues datapath strobes and status.
// The slave side is the requester, consumer and datapath that surround it.
interface mult_seq_controller_if #(
  parameter int WIDTH = 16
);
  localparam int CW = $clog2(WIDTH);

  // Start request from the requester (operands already on datapath inputs)
  logic          start_valid;
  logic          start_ready;

  // Feedback from the datapath
  logic          multiplier_lsb;
  logic          count_check;

  // Datapath control strobes
  logic          load_words;
  logic          add_shift;
  logic          shift;
  logic          ready;

  // Completion handshake towards the consumer
  logic          done_valid;
  logic          done_ready;

  // Status
  logic          busy;
  logic [CW-1:0] iter_cnt;
  logic          protocol_err;

  modport master (
    input  start_valid,
    input  multiplier_lsb,
    input  count_check,
    input  done_ready,
    output start_ready,
    output load_words,
    output add_shift,
    output shift,
    output ready,
    output done_valid,
    output busy,
    output iter_cnt,
    output protocol_err
  );

  modport slave (
    output start_valid,
    output multiplier_lsb,
    output count_check,
    output done_ready,
    input  start_ready,
    input  load_words,
    input  add_shift,
    input  shift,
    input  ready,
    input  done_valid,
    input  busy,
    input  iter_cnt,
    input  protocol_err
  );
endinterface

// File: rtl/mult_seq_controller.sv
// Control FSM for a WIDTH x WIDTH shift-and-add sequential multiplier.
// IDLE accepts a start, LOAD strobes the operands in, ITER issues one
// add_shift/shift per multiplier bit, DONE holds the product valid until the
// consumer takes it. The datapath's own terminal-count flag is cross-checked
// against the local iteration counter; any disagreement raises a sticky
// protocol_err that is cleared when the next operation loads.
module mult_seq_controller #(
  parameter int WIDTH = 16,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  mult_seq_controller_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] iter_cnt_q, iter_cnt_d;
  logic          protocol_err_q, protocol_err_d;

  logic          last_iter;

  // Control outputs, decoded from state (plus multiplier_lsb during ITER)
  logic          start_ready_o;
  logic          load_words_o;
  logic          add_shift_o;
  logic          shift_o;
  logic          ready_o;
  logic          done_valid_o;
  logic          busy_o;

  assign last_iter = (iter_cnt_q == LAST_ITER);

  // State, iteration counter and sticky error register
  // NOTE: reset is asynchronous so an abort lands immediately, even mid-sequence;
  // every sequential assignment is non-blocking so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      iter_cnt_q     <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      iter_cnt_q     <= iter_cnt_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  // Next-state, counter/error update and output decode
  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    iter_cnt_d     = iter_cnt_q;
    protocol_err_d = protocol_err_q;

    start_ready_o  = 1'b0;
    load_words_o   = 1'b0;
    add_shift_o    = 1'b0;
    shift_o        = 1'b0;
    ready_o        = 1'b0;
    done_valid_o   = 1'b0;
    busy_o         = 1'b0;

    unique case (state_q)
      IDLE: begin
        start_ready_o = 1'b1;
        if (bus.start_valid) begin
          state_d = LOAD;
        end
      end

      LOAD: begin
        load_words_o   = 1'b1;
        busy_o         = 1'b1;
        // Fresh operation: restart the count and forget any earlier error
        iter_cnt_d     = '0;
        protocol_err_d = 1'b0;
        state_d        = ITER;
      end

      ITER: begin
        busy_o      = 1'b1;
        add_shift_o = bus.multiplier_lsb;
        shift_o     = ~bus.multiplier_lsb;
        if (last_iter) begin
          // Datapath must agree that this is the terminal iteration
          if (!bus.count_check) begin
            protocol_err_d = 1'b1;
          end
          state_d = DONE;
        end else begin
          // Terminal flag before the last iteration is an error, but the
          // sequence still runs its full length
          if (bus.count_check) begin
            protocol_err_d = 1'b1;
          end
          iter_cnt_d = iter_cnt_q + CW'(1);
        end
      end

      DONE: begin
        done_valid_o = 1'b1;
        ready_o      = 1'b1;
        if (bus.done_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.start_ready  = start_ready_o;
  assign bus.load_words   = load_words_o;
  assign bus.add_shift    = add_shift_o;
  assign bus.shift        = shift_o;
  assign bus.ready        = ready_o;
  assign bus.done_valid   = done_valid_o;
  assign bus.busy         = busy_o;
  assign bus.iter_cnt     = iter_cnt_q;
  assign bus.protocol_err = protocol_err_q;

  // Datapath strobes never overlap
  assert property (@(posedge clk) disable iff (reset)
    $onehot0({load_words_o, add_shift_o, shift_o}));

endmodule

// File: tb/tb_mult_seq_controller.sv
// Directed testbench for mult_seq_controller (WIDTH = 16).
module tb_mult_seq_controller;

  localparam int WIDTH = 16;
  localparam int CW    = $clog2(WIDTH);
  localparam int T_CLK = 10;

  logic clk;
  logic reset;

  int checks = 0;
  int errors = 0;

  mult_seq_controller_if #(.WIDTH(WIDTH)) bus ();

  mult_seq_controller #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #(T_CLK / 2) clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  // Advance one clock; outputs are settled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leave DONE through the completion handshake
  task automatic finish_done();
    bus.done_ready = 1'b1;
    step();
    bus.done_ready = 1'b0;
  endtask

  // Run one multiplication: request a start, record the strobes of each ITER
  // cycle (bit i = iteration i) and return at the first DONE cycle.
  task automatic run_op(
    input  logic [15:0] lsb_pat,
    input  logic [15:0] cc_pat,
    input  logic        dr,
    output int          lat,
    output logic [15:0] o_add,
    output logic [15:0] o_shift,
    output logic [15:0] o_err,
    output int          iter_bad,
    output logic        load_ok,
    output logic        err_in_load,
    output longint      t_acc
  );
    logic acc;
    acc         = 1'b0;
    lat         = -1;
    o_add       = '0;
    o_shift     = '0;
    o_err       = '0;
    iter_bad    = 0;
    load_ok     = 1'b0;
    err_in_load = 1'b0;
    t_acc       = 0;
    bus.done_ready     = dr;
    bus.multiplier_lsb = 1'b1;
    bus.count_check    = 1'b0;
    bus.start_valid    = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (bus.load_words === 1'b1) begin
        acc = 1'b1;
        break;
      end
    end
    bus.start_valid = 1'b0;
    if (acc) begin
      t_acc = longint'($time) - 1;
      #1;
      // multiplier_lsb is high here and must not leak into LOAD
      load_ok = bus.load_words & bus.busy & ~bus.add_shift & ~bus.shift &
                ~bus.start_ready & ~bus.done_valid;
      err_in_load = bus.protocol_err;
      for (int c = 1; c <= 40; c++) begin
        step();
        if (bus.done_valid === 1'b1) begin
          lat = c;
          break;
        end
        if (c <= WIDTH) begin
          bus.multiplier_lsb = lsb_pat[c-1];
          bus.count_check    = cc_pat[c-1];
          #1;
          o_add[c-1]   = bus.add_shift;
          o_shift[c-1] = bus.shift;
          o_err[c-1]   = bus.protocol_err;
          if (bus.iter_cnt !== CW'(c - 1)) iter_bad++;
        end
      end
    end
    bus.multiplier_lsb = 1'b0;
    bus.count_check    = 1'b0;
  endtask

  task automatic test_reset();
    reset              = 1'b1;
    bus.start_valid    = 1'b0;
    bus.multiplier_lsb = 1'b1;
    bus.count_check    = 1'b1;
    bus.done_ready     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.start_ready, bus.load_words, bus.add_shift, bus.shift, bus.ready,
         bus.done_valid, bus.busy, bus.protocol_err} !== 8'b1000_0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 10000000",
               {bus.start_ready, bus.load_words, bus.add_shift, bus.shift, bus.ready,
                bus.done_valid, bus.busy, bus.protocol_err});
    end
    checks++;
    if (bus.iter_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_iter_cnt: got %0d expected 0", bus.iter_cnt);
    end
    @(negedge clk);
    reset              = 1'b0;
    bus.multiplier_lsb = 1'b0;
    bus.count_check    = 1'b0;
    bus.done_ready     = 1'b0;
    step();
    checks++;
    if ({bus.start_ready, bus.busy, bus.done_valid} !== 3'b100) begin
      errors++;
      $display("FAIL idle_after_reset: got %b expected 100",
               {bus.start_ready, bus.busy, bus.done_valid});
    end
  endtask

  task automatic test_bit_pattern();
    int lat, iter_bad;
    logic [15:0] o_add, o_shift, o_err;
    logic load_ok, err_in_load;
    longint t_acc;
    run_op(16'h00A5, 16'h8000, 1'b0, lat, o_add, o_shift, o_err, iter_bad,
           load_ok, err_in_load, t_acc);
    checks++;
    if (lat !== 17) begin
      errors++;
      $display("FAIL pattern_latency: got %0d expected 17", lat);
    end
    checks++;
    if (load_ok !== 1'b1) begin
      errors++;
      $display("FAIL pattern_load_cycle: got %b expected 1", load_ok);
    end
    checks++;
    if (o_add !== 16'h00A5) begin
      errors++;
      $display("FAIL pattern_add_shift: got %h expected 00a5", o_add);
    end
    checks++;
    if (o_shift !== 16'hFF5A) begin
      errors++;
      $display("FAIL pattern_shift: got %h expected ff5a", o_shift);
    end
    checks++;
    if (o_err !== 16'h0000 || iter_bad !== 0) begin
      errors++;
      $display("FAIL pattern_iter_status: err %h bad_cnt %0d expected 0000 0", o_err, iter_bad);
    end
    checks++;
    if ({bus.done_valid, bus.ready, bus.busy, bus.start_ready, bus.protocol_err,
         bus.load_words, bus.add_shift, bus.shift} !== 8'b1100_0000) begin
      errors++;
      $display("FAIL pattern_done_outputs: got %b expected 11000000",
               {bus.done_valid, bus.ready, bus.busy, bus.start_ready, bus.protocol_err,
                bus.load_words, bus.add_shift, bus.shift});
    end
    checks++;
    if (bus.iter_cnt !== 4'd15) begin
      errors++;
      $display("FAIL pattern_done_iter_cnt: got %0d expected 15", bus.iter_cnt);
    end
    finish_done();
    checks++;
    if ({bus.start_ready, bus.done_valid, bus.ready} !== 3'b100) begin
      errors++;
      $display("FAIL pattern_back_to_idle: got %b expected 100",
               {bus.start_ready, bus.done_valid, bus.ready});
    end
  endtask

  task automatic test_stalled_consumer();
    int lat, iter_bad;
    logic [15:0] o_add, o_shift, o_err;
    logic load_ok, err_in_load;
    longint t_acc;
    logic found;
    run_op(16'h0F0F, 16'h8000, 1'b0, lat, o_add, o_shift, o_err, iter_bad,
           load_ok, err_in_load, t_acc);
    checks++;
    if (lat !== 17) begin
      errors++;
      $display("FAIL stall_latency: got %0d expected 17", lat);
    end
    bus.start_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({bus.done_valid, bus.ready, bus.start_ready, bus.load_words} !== 4'b1100) begin
        errors++;
        $display("FAIL stall_hold_%0d: got %b expected 1100", k,
                 {bus.done_valid, bus.ready, bus.start_ready, bus.load_words});
      end
      step();
    end
    bus.done_ready = 1'b1;
    step();
    bus.done_ready = 1'b0;
    checks++;
    if ({bus.start_ready, bus.done_valid, bus.load_words, bus.busy} !== 4'b1000) begin
      errors++;
      $display("FAIL stall_release_idle: got %b expected 1000",
               {bus.start_ready, bus.done_valid, bus.load_words, bus.busy});
    end
    step();
    checks++;
    if ({bus.load_words, bus.busy, bus.start_ready} !== 3'b110) begin
      errors++;
      $display("FAIL stall_pending_start: got %b expected 110",
               {bus.load_words, bus.busy, bus.start_ready});
    end
    bus.start_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.done_valid === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (found !== 1'b1) begin
      errors++;
      $display("FAIL stall_second_done: got %b expected 1", found);
    end
    finish_done();
  endtask

  task automatic test_early_count_check();
    int lat, iter_bad;
    logic [15:0] o_add, o_shift, o_err;
    logic load_ok, err_in_load;
    longint t_acc;
    run_op(16'h1234, 16'h8200, 1'b0, lat, o_add, o_shift, o_err, iter_bad,
           load_ok, err_in_load, t_acc);
    checks++;
    if (lat !== 17) begin
      errors++;
      $display("FAIL early_latency: got %0d expected 17", lat);
    end
    checks++;
    if (o_err !== 16'hFC00) begin
      errors++;
      $display("FAIL early_err_timing: got %h expected fc00", o_err);
    end
    checks++;
    if (o_add !== 16'h1234 || o_shift !== 16'hEDCB) begin
      errors++;
      $display("FAIL early_full_iterations: add %h shift %h expected 1234 edcb", o_add, o_shift);
    end
    finish_done();
    checks++;
    if ({bus.start_ready, bus.protocol_err} !== 2'b11) begin
      errors++;
      $display("FAIL early_err_sticky_idle: got %b expected 11",
               {bus.start_ready, bus.protocol_err});
    end
    run_op(16'h0001, 16'h8000, 1'b0, lat, o_add, o_shift, o_err, iter_bad,
           load_ok, err_in_load, t_acc);
    checks++;
    if (err_in_load !== 1'b1 || o_err !== 16'h0000) begin
      errors++;
      $display("FAIL early_err_cleared_by_load: load %b iter %h expected 1 0000",
               err_in_load, o_err);
    end
    checks++;
    if ({bus.done_valid, bus.protocol_err} !== 2'b10) begin
      errors++;
      $display("FAIL early_clean_done: got %b expected 10", {bus.done_valid, bus.protocol_err});
    end
    finish_done();
  endtask

  task automatic test_missing_count_check();
    int lat, iter_bad;
    logic [15:0] o_add, o_shift, o_err;
    logic load_ok, err_in_load;
    longint t_acc;
    run_op(16'hFFFF, 16'h0000, 1'b0, lat, o_add, o_shift, o_err, iter_bad,
           load_ok, err_in_load, t_acc);
    checks++;
    if (lat !== 17 || o_err !== 16'h0000) begin
      errors++;
      $display("FAIL missing_iter: latency %0d err %h expected 17 0000", lat, o_err);
    end
    checks++;
    if (o_add !== 16'hFFFF || o_shift !== 16'h0000) begin
      errors++;
      $display("FAIL missing_strobes: add %h shift %h expected ffff 0000", o_add, o_shift);
    end
    checks++;
    if ({bus.done_valid, bus.ready, bus.protocol_err} !== 3'b111) begin
      errors++;
      $display("FAIL missing_done_err: got %b expected 111",
               {bus.done_valid, bus.ready, bus.protocol_err});
    end
    finish_done();
  endtask

  task automatic test_zero_operand();
    int lat, iter_bad;
    logic [15:0] o_add, o_shift, o_err;
    logic load_ok, err_in_load;
    longint t1, t2;
    run_op(16'h0000, 16'h8000, 1'b1, lat, o_add, o_shift, o_err, iter_bad,
           load_ok, err_in_load, t1);
    checks++;
    if (lat !== 17 || o_add !== 16'h0000 || o_shift !== 16'hFFFF) begin
      errors++;
      $display("FAIL zero_strobes: latency %0d add %h shift %h expected 17 0000 ffff",
               lat, o_add, o_shift);
    end
    step();
    checks++;
    if ({bus.done_valid, bus.start_ready} !== 2'b01) begin
      errors++;
      $display("FAIL zero_one_cycle_done: got %b expected 01", {bus.done_valid, bus.start_ready});
    end
    run_op(16'h0000, 16'h8000, 1'b1, lat, o_add, o_shift, o_err, iter_bad,
           load_ok, err_in_load, t2);
    checks++;
    if ((t2 - t1) / T_CLK !== 64'sd19) begin
      errors++;
      $display("FAIL zero_start_period: got %0d expected 19", (t2 - t1) / T_CLK);
    end
    step();
    bus.done_ready = 1'b0;
  endtask

  task automatic test_reset_mid_iter();
    bus.start_valid = 1'b1;
    step();
    bus.start_valid    = 1'b0;
    bus.multiplier_lsb = 1'b1;
    for (int idx = 0; idx < 8; idx++) begin
      step();
      bus.multiplier_lsb = 1'b1;
      bus.count_check    = (idx == 2);
    end
    bus.count_check = 1'b0;
    #1;
    checks++;
    if ({bus.iter_cnt, bus.add_shift, bus.protocol_err} !== {4'd7, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL midreset_before: cnt %0d add %b err %b expected 7 1 1",
               bus.iter_cnt, bus.add_shift, bus.protocol_err);
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.start_ready, bus.add_shift, bus.shift, bus.busy, bus.load_words,
         bus.done_valid, bus.ready} !== 7'b1000000 || bus.iter_cnt !== 4'd0) begin
      errors++;
      $display("FAIL midreset_async: got %b cnt %0d expected 1000000 0",
               {bus.start_ready, bus.add_shift, bus.shift, bus.busy, bus.load_words,
                bus.done_valid, bus.ready}, bus.iter_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) step();
    checks++;
    if ({bus.start_ready, bus.busy, bus.protocol_err, bus.add_shift} !== 4'b1000 ||
        bus.iter_cnt !== 4'd0) begin
      errors++;
      $display("FAIL midreset_no_resume: got %b cnt %0d expected 1000 0",
               {bus.start_ready, bus.busy, bus.protocol_err, bus.add_shift}, bus.iter_cnt);
    end
    bus.multiplier_lsb = 1'b0;
  endtask

  initial begin
    reset              = 1'b1;
    bus.start_valid    = 1'b0;
    bus.multiplier_lsb = 1'b0;
    bus.count_check    = 1'b0;
    bus.done_ready     = 1'b0;
    test_reset();
    test_bit_pattern();
    test_stalled_consumer();
    test_early_count_check();
    test_missing_count_check();
    test_zero_operand();
    test_reset_mid_iter();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_seq_controller.md
Name: mult_seq_controller

Overview:
- Control FSM sitting directly upstream of the 16x16 sequential multiplier datapath.
- Accepts a start request over a valid/ready handshake and pulses `load_words`.
- Issues one `add_shift` or `shift` per multiplier bit, depending on the multiplier LSB returned by the datapath.
- Cross-checks the datapath's `count_check` against its own iteration counter, then presents completion over a valid/ready handshake and asserts `ready` to the datapath.

Parameters:
WIDTH, 16, operand width = number of iterations issued per multiplication (≥2)
CW, $clog2(WIDTH), width of the iteration counter output

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start_valid  input  1  requester has operands stable on datapath inputs
start_ready  output  1  controller can accept a start (IDLE only)
multiplier_lsb  input  1  bit 0 of the datapath's shifted multiplier register
count_check  input  1  datapath counter terminal flag
load_words  output  1  load operands into datapath
add_shift  output  1  accumulate multiplicand then shift
shift  output  1  shift without accumulate
ready  output  1  product valid at datapath output
done_valid  output  1  multiplication complete
done_ready  input  1  consumer accepts completion
busy  output  1  high in LOAD and ITER
iter_cnt  output  CW  current iteration index
protocol_err  output  1  sticky count_check mismatch flag

Behaviour:
- States: IDLE, LOAD, ITER, DONE. Registered state; all outputs are Moore-decoded from state, except `add_shift`/`shift`, which also depend on `multiplier_lsb`.
- Reset, asynchronous at any time including mid-operation:
  - state=IDLE, iter_cnt=0, protocol_err=0.
  - All control outputs 0 except start_ready=1.
  - No partial sequence resumes after reset.
- IDLE:
  - start_ready=1; all other control outputs 0.
  - start_valid=1 at an edge → LOAD.
- LOAD (exactly 1 cycle):
  - load_words=1, busy=1.
  - iter_cnt←0 and protocol_err←0 at exit.
  - → ITER.
- ITER (exactly WIDTH cycles):
  - busy=1.
  - add_shift = multiplier_lsb; shift = ~multiplier_lsb. Exactly one of them is high every ITER cycle.
  - iter_cnt increments at each edge.
  - When iter_cnt==WIDTH-1: sample count_check. count_check=0 sets protocol_err. Then → DONE.
  - count_check=1 while iter_cnt<WIDTH-1 also sets protocol_err; the sequence still runs the full WIDTH iterations.
- DONE:
  - done_valid=1, ready=1, iter_cnt holds WIDTH-1.
  - done_valid && done_ready at an edge → IDLE.
  - done_ready may be high in the first DONE cycle: DONE then lasts 1 cycle.
- Latency: start handshake at edge E → load_words high during cycle E..E+1 → ITER during E+1..E+WIDTH+1 → done_valid visible after edge E+WIDTH+1 (17 cycles for WIDTH=16).
- Back-to-back operation: start_ready=0 in DONE, so a new start is accepted no earlier than the cycle after DONE exits. Minimum start-to-start period is WIDTH+3 cycles.
- Inputs outside their relevant state are ignored:
  - start_valid while busy or in DONE is not queued.
  - done_ready in IDLE/LOAD/ITER has no effect.
  - multiplier_lsb outside ITER is ignored.
- protocol_err holds from the point it is set until the next LOAD or reset.
- load_words, add_shift and shift are mutually exclusive in every cycle.

Test Plan:
- Reset mid-ITER: assert reset at iter_cnt=7 → same cycle: state IDLE, add_shift=shift=0, start_ready=1, iter_cnt=0; protocol_err=0 after release.
- Bit pattern: start with multiplier 0x00A5 modelled, LSB stream 1,0,1,0,0,1,0,1,0×8; count_check=1 only at iteration 15:
  - add_shift high on iterations 0,2,5,7; shift high on the other 12.
  - done_valid rises 17 cycles after the start edge; protocol_err=0.
- Stalled consumer: done_ready=0 for 5 cycles after done_valid → done_valid and ready held 5 cycles; start_valid=1 during that time is not accepted (start_ready=0). With done_ready=1, IDLE follows, and the pending start is accepted at the next edge.
- Early count_check: assert count_check at iteration 9 and at iteration 15 → protocol_err=1 from iteration 10 onward; full 16 iterations still issued; protocol_err cleared by the next LOAD.
- Missing count_check: count_check=0 throughout → protocol_err=1 in DONE; done_valid still asserted normally.
- Zero operand: all LSBs 0 → 16 shift pulses, 0 add_shift; immediate done_ready=1 gives a 1-cycle DONE; a second start gives period 19 cycles.
